// File: rtl/regfile_8x16_pkg.sv
// Shared datapath constants for the register file, ALU operand mux and decode.
package regfile_8x16_pkg;
   localparam int WIDTH    = 16;
   localparam int NREG     = 8;
   localparam int AW       = 3;
   localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_8x16_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination outstanding, writeback retires it,
// and reads of an outstanding register raise stall unless bypassed this cycle.
module regfile_8x16_scoreboard
   import regfile_8x16_pkg::*;
#(
   parameter int NREG = regfile_8x16_pkg::NREG,
   parameter int AW   = regfile_8x16_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iss_v,
   input  logic [AW-1:0] iss_rd,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic          stall
);

   logic [NREG-1:0] busy;
   logic            hz1, hz2;

   // Bit 0 is only ever written by reset, so it stays clear. Set is checked
   // first: a fresh producer on the same index keeps the register busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (iss_v && iss_rd == AW'(i))
               busy[i] <= 1'b1;
            else if (we && wa == AW'(i))
               busy[i] <= 1'b0;
         end
      end
   end

   assign hz1   = (ra1 != AW'(ZERO_REG)) & busy[ra1] & ~(we & (wa == ra1));
   assign hz2   = (ra2 != AW'(ZERO_REG)) & busy[ra2] & ~(we & (wa == ra2));
   assign stall = hz1 | hz2;

endmodule

// File: rtl/regfile_8x16.sv
// 8x16 register file: two combinational read ports with write-through bypass,
// one synchronous write port, r0 hardwired to zero, busy-bit stall generation.
module regfile_8x16
   import regfile_8x16_pkg::*;
#(
   parameter int WIDTH = regfile_8x16_pkg::WIDTH,
   parameter int NREG  = regfile_8x16_pkg::NREG,
   parameter int AW    = regfile_8x16_pkg::AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             iss_v,
   input  logic [AW-1:0]    iss_rd,
   output logic             stall
);

   logic [NREG-1:0][WIDTH-1:0] regs;

   always_ff @(posedge clk) begin
      if (rst)
         regs <= '0;
      else if (we && wa != AW'(ZERO_REG))
         regs[wa] <= wd;
   end

   // r0 override comes last so a discarded write to r0 can never bypass out.
   always_comb begin
      rd1 = regs[ra1];
      if (we && wa == ra1) rd1 = wd;
      if (ra1 == AW'(ZERO_REG)) rd1 = '0;
      rd2 = regs[ra2];
      if (we && wa == ra2) rd2 = wd;
      if (ra2 == AW'(ZERO_REG)) rd2 = '0;
   end

   regfile_8x16_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
      .clk    (clk),
      .rst    (rst),
      .iss_v  (iss_v),
      .iss_rd (iss_rd),
      .we     (we),
      .wa     (wa),
      .ra1    (ra1),
      .ra2    (ra2),
      .stall  (stall)
   );

endmodule

// File: tb/tb_regfile_8x16.sv
// Cycle-by-cycle vector table for regfile_8x16; expected outputs are queued
// when a vector is driven and popped when the combinational outputs are sampled.
module tb_regfile_8x16;

   logic        clk = 1'b0;
   logic        rst, we, iss_v;
   logic [2:0]  wa, ra1, ra2, iss_rd;
   logic [15:0] wd, rd1, rd2;
   logic        stall;

   typedef struct {
      logic        rst, we, iss_v;
      logic [2:0]  wa, iss_rd, ra1, ra2;
      logic [15:0] wd;
      logic [15:0] e1, e2;
      logic        es;
   } vec_t;

   typedef struct {
      logic [15:0] e1, e2;
      logic        es;
      int          id;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   regfile_8x16 dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .iss_v(iss_v), .iss_rd(iss_rd), .stall(stall)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic w, input logic [2:0] a,
                               input logic [15:0] d, input logic iv, input logic [2:0] ir,
                               input logic [2:0] r1, input logic [2:0] r2,
                               input logic [15:0] e1, input logic [15:0] e2, input logic es);
      vec_t v;
      v.rst = r; v.we = w; v.wa = a; v.wd = d; v.iss_v = iv; v.iss_rd = ir;
      v.ra1 = r1; v.ra2 = r2; v.e1 = e1; v.e2 = e2; v.es = es;
      return v;
   endfunction

   task automatic check(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s vec%0d: got %h want %h", nm, id, act, req);
      end
   endtask

   // Drive on the falling edge, sample 2ns later, well before the next rising edge.
   task automatic apply(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      rst = v.rst; we = v.we; wa = v.wa; wd = v.wd;
      iss_v = v.iss_v; iss_rd = v.iss_rd; ra1 = v.ra1; ra2 = v.ra2;
      e.e1 = v.e1; e.e2 = v.e2; e.es = v.es; e.id = id;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      check("rd1",   e.id, rd1, e.e1);
      check("rd2",   e.id, rd2, e.e2);
      check("stall", e.id, {15'd0, stall}, {15'd0, e.es});
   endtask

   initial begin
      int id;
      logic [15:0] p, q;
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_rd = '0; ra1 = '0; ra2 = '0;
      repeat (2) @(posedge clk);

      //            rst we wa  wd        iv ir  ra1 ra2  rd1       rd2       stall
      tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 3, 7, 16'h0000, 16'h0000, 0)); // reset state
      tbl.push_back(mk(0, 1, 3, 16'h1234, 1, 3, 3, 0, 16'h1234, 16'h0000, 0)); // preload r3, busy3
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 3, 0, 16'h1234, 16'h0000, 1));
      tbl.push_back(mk(1, 1, 3, 16'h5555, 0, 0, 3, 0, 16'h5555, 16'h0000, 0)); // rst beats we
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 3, 3, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 5, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 16'h0000, 0)); // write r5
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 5, 5, 16'hBEEF, 16'hBEEF, 0));
      tbl.push_back(mk(0, 1, 2, 16'h0001, 0, 0, 7, 6, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 2, 16'hA5A5, 0, 0, 2, 5, 16'hA5A5, 16'hBEEF, 0)); // bypass
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 2, 16'hA5A5, 16'hA5A5, 0));
      tbl.push_back(mk(0, 1, 0, 16'hFFFF, 1, 0, 0, 0, 16'h0000, 16'h0000, 0)); // r0
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 4, 5, 4, 16'hBEEF, 16'h0000, 0)); // issue r4
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 4, 16'h0000, 16'h0000, 1));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 4, 16'h0000, 16'h0000, 1));
      tbl.push_back(mk(0, 1, 4, 16'h0042, 0, 0, 0, 4, 16'h0000, 16'h0042, 0)); // retire r4
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 4, 16'h0000, 16'h0042, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 6, 1, 2, 16'h0000, 16'hA5A5, 0)); // issue r6
      tbl.push_back(mk(0, 1, 6, 16'h6666, 1, 6, 6, 0, 16'h6666, 16'h0000, 0)); // set/clear collide
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 6, 0, 16'h6666, 16'h0000, 1));
      tbl.push_back(mk(0, 1, 6, 16'h7777, 1, 1, 1, 6, 16'h0000, 16'h7777, 0)); // distinct set/clear
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 6, 16'h0000, 16'h7777, 1));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 6, 0, 16'h7777, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 7, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 7, 5, 16'hFFFF, 16'hBEEF, 0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
      id = tbl.size();

      // Fill every register with a distinct pattern, reading it through the bypass.
      for (int r = 1; r < 8; r++) begin
         p = 16'h1111 * 16'(r);
         apply(mk(0, 1, 3'(r), p, 0, 0, 3'(r), 0, p, 16'h0000, 0), id++);
      end
      // Read every pair back from storage; all writes retired, so no stall.
      for (int r = 1; r < 8; r++) begin
         p = 16'h1111 * 16'(r);
         q = 16'h1111 * 16'(8 - r);
         apply(mk(0, 0, 0, 16'h0000, 0, 0, 3'(r), 3'(8 - r), p, q, 0), id++);
      end

      // Reset in the same cycle as an issue: the busy bit must not survive.
      apply(mk(1, 0, 0, 16'h0000, 1, 2, 2, 0, 16'h2222, 16'h0000, 0), id++);
      apply(mk(0, 0, 0, 16'h0000, 0, 0, 2, 7, 16'h0000, 16'h0000, 0), id++);

      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_8x16.md
Name: regfile_8x16

Overview:
- 8-entry x 16-bit general-purpose register file with two combinational read ports and one synchronous write port.
- Includes a busy-bit scoreboard that raises a stall when a read operand has a write still outstanding.
- Sits directly upstream of the ALU operand-select mux (mux16_21).
  - rd1 feeds the ALU A operand.
  - rd2 feeds the mux data input, where it is selected against the sign-extended immediate.
- The writeback stage drives the write port. The issue stage drives the scoreboard set port.

Parameters:
- WIDTH, 16, data width of each register.
- NREG, 8, number of registers (power of two).
- AW, 3, address width; must equal log2(NREG).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable for the writeback port.
- wa  input  AW  write address.
- wd  input  WIDTH  write data.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- iss_v  input  1  issue valid: an instruction with destination iss_rd is issued this cycle.
- iss_rd  input  AW  destination register of the issuing instruction.
- stall  output  1  high when ra1 or ra2 hazards against an outstanding write.

Behaviour:
- Reset:
  - Decided: one clock; reset is synchronous and active-high (clk, rst).
  - When rst=1 at a rising edge, all registers clear to 0 and all busy bits clear to 0.
  - rst takes priority over we and iss_v in the same cycle.
  - Reset outputs are rd1=0, rd2=0, stall=0, valid from the first edge with rst=1 (since all state reads 0).
- Register 0 is hardwired:
  - Reads of address 0 always return 0.
  - Writes to address 0 are discarded.
  - busy[0] never sets.
- Write:
  - If we=1 and wa!=0, reg[wa] <= wd on the rising edge.
  - Latency: 1 cycle to storage.
- Read:
  - rd1 and rd2 are combinational from ra1, ra2 and storage.
  - Write-through bypass: if we=1, wa!=0 and wa==raN, then rdN=wd in the same cycle.
  - Both ports may read the same address; both then return identical data.
- Scoreboard, busy[NREG-1:0]:
  - Set: iss_v=1 and iss_rd!=0 sets busy[iss_rd] at the edge.
  - Clear: we=1 and wa!=0 clears busy[wa] at the edge.
  - Simultaneous set and clear of the same index: set wins. A new producer was issued, so the register stays busy.
  - Set and clear of different indices in the same cycle: both take effect.
- Stall (combinational):
  - stall = hz(ra1) | hz(ra2), where hz(r) = (r!=0) & busy[r] & ~(we & wa==r).
  - A register being written this cycle is not a hazard, because the bypass supplies its data.
  - stall does not depend on iss_v in the same cycle; a current issue only affects later cycles.
- Out-of-range addresses cannot occur because AW matches NREG.
- No X on outputs after the first reset edge.

Decomposition:
- Shared package/header (for example proc_defs): WIDTH=16, AW=3, NREG=8, and the constant ZERO_REG=0.
- The ALU, mux stages and decode stage share these constants.
- Natural sub-module: reg_scoreboard, holding the busy vector and its set/clear/stall logic.
- Storage array and bypass stay in the top module.

Test Plan:
- Reset: preload reg3=0x1234 and busy[3]=1, then hold rst=1 one cycle with we=1, wa=3 -> reg3 reads 0x0000, stall=0, busy clear.
- Write then read: we=1, wa=5, wd=0xBEEF; next cycle ra1=5, ra2=5 -> rd1=rd2=0xBEEF.
- Bypass: reg2=0x0001; in one cycle we=1, wa=2, wd=0xA5A5 with ra1=2 -> rd1=0xA5A5 combinationally, and reg2=0xA5A5 afterwards.
- R0: we=1, wa=0, wd=0xFFFF, and iss_v=1, iss_rd=0 -> ra1=0 reads 0x0000, busy[0]=0, stall=0.
- Hazard: iss_v=1, iss_rd=4; next cycle ra2=4 -> stall=1.
  - Hold until we=1, wa=4, wd=0x0042 -> that cycle stall=0 and rd2=0x0042.
  - Following cycle busy[4]=0.
- Set/clear collision: busy[6]=1; in one cycle we=1, wa=6 and iss_v=1, iss_rd=6 -> busy[6] stays 1; next cycle ra1=6 -> stall=1.
